// File: rtl/float_mul_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency, non-stallable float multiplier.
// Credits (in-flight + buffered) gate admission so the result FIFO can never overflow.
module float_mul_stream_ctrl #(
  parameter  int MANTISSA_SIZE = 23,
  parameter  int EXPONENT_SIZE = 8,
  parameter  int MUL_LATENCY   = 4,
  parameter  int FIFO_DEPTH    = 8,
  localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE,
  localparam int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FLOAT_SIZE-1:0] s_facA,
  input  logic [FLOAT_SIZE-1:0] s_facB,
  output logic [FLOAT_SIZE-1:0] mul_facA,
  output logic [FLOAT_SIZE-1:0] mul_facB,
  input  logic [FLOAT_SIZE-1:0] mul_prod,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLOAT_SIZE-1:0] m_prod,
  output logic [CNT_W-1:0]      level,
  output logic                  busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [SUM_W-1:0] CREDITS  = SUM_W'(FIFO_DEPTH);

  logic [MUL_LATENCY-1:0] vld;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       rptr;
  logic [PTR_W-1:0]       wptr;
  logic [FLOAT_SIZE-1:0]  mem [FIFO_DEPTH];

  logic             accept;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] credit_sum;

  // The multiplier samples the operands directly; the controller only tracks validity.
  assign mul_facA = s_facA;
  assign mul_facB = s_facB;

  assign credit_sum = {1'b0, inflight} + {1'b0, count};
  assign s_ready    = credit_sum < CREDITS;
  assign m_valid    = (count != '0);
  assign accept     = s_valid && s_ready;
  assign push       = vld[MUL_LATENCY-1];
  assign pop        = m_valid && m_ready;
  assign level      = count;
  assign busy       = (inflight != '0) || (count != '0);

  // Head is forced to zero while empty so reset and idle never expose uninitialised RAM.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    m_prod = '0;
    if (m_valid) m_prod = mem[rptr];
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld      <= '0;
      inflight <= '0;
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
    end else begin
      vld[0] <= accept;
      for (int i = 1; i < MUL_LATENCY; i++) vld[i] <= vld[i-1];

      inflight <= inflight + CNT_W'(accept) - CNT_W'(push);

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
    end
  end

  // NOTE: storage array has no reset; m_prod gating and count make its contents irrelevant until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= mul_prod;
  end

endmodule

// File: tb/tb_float_mul_stream_ctrl.sv
// Directed bench for float_mul_stream_ctrl: a behavioural multiplier stand-in, a
// queue-based occupancy/order model checked every cycle, and literal expectations.
module tb_float_mul_stream_ctrl;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int FW = 32;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_valid, s_ready, m_valid, m_ready, busy;
  logic [FW-1:0] s_facA, s_facB, mul_facA, mul_facB, mul_prod, m_prod;
  logic [CW-1:0] level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_mul_stream_ctrl #(
    .MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .MUL_LATENCY(L), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_facA(s_facA), .s_facB(s_facB),
    .mul_facA(mul_facA), .mul_facB(mul_facB), .mul_prod(mul_prod),
    .m_valid(m_valid), .m_ready(m_ready), .m_prod(m_prod),
    .level(level), .busy(busy)
  );

  // Single-precision multiply for normal operands, truncating the mantissa.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom();
    e = 8'($urandom_range(100, 154));
    return {r[31], e, r[22:0]};
  endfunction

  // Multiplier stand-in: samples at edge t, result stable after edge t+L-1.
  logic [FW-1:0] mp [L];
  always @(posedge clk) begin
    mp[0] <= fmul(mul_facA, mul_facB);
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign mul_prod = mp[L-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: every accepted op is queued with its accepting edge; it sits in the
  // FIFO once L edges have passed, and leaves in order on each pop.
  typedef struct {
    int          acc_edge;
    logic [31:0] prod;
  } item_t;

  item_t         q[$];
  logic [31:0]   popped[$];
  int            edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    int in_fifo;
    if (!resetn) begin
      q.delete();
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_level",   32'(level),   32'd0);
      check("rst_busy",    32'(busy),    32'd0);
    end else begin
      in_fifo = 0;
      foreach (q[i]) if (q[i].acc_edge + L <= edge_n) in_fifo++;
      check("level",   32'(level),   32'(in_fifo));
      check("m_valid", 32'(m_valid), 32'(in_fifo != 0));
      check("s_ready", 32'(s_ready), 32'(q.size() < D));
      check("busy",    32'(busy),    32'(q.size() != 0));
      if (in_fifo > D) check("overflow", 32'(in_fifo), 32'(D));
      if (m_valid && m_ready) begin
        popped.push_back(m_prod);
        if (in_fifo > 0) begin
          check("m_prod", m_prod, q[0].prod);
          void'(q.pop_front());
        end
      end
      if (s_valid && s_ready) q.push_back('{edge_n + 1, fmul(s_facA, s_facB)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    s_valid = 1'b0;
    m_ready = 1'b1;
    k = 0;
    while (busy && k < 100) begin
      step();
      k++;
    end
    check("drain_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int t, acc, k, stale;
    resetn  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_facA  = '0;
    s_facB  = '0;

    check("pin_2x3",    fmul(32'h40000000, 32'h40400000), 32'h40C00000);
    check("pin_1p5xm2", fmul(32'h3FC00000, 32'hC0000000), 32'hC0400000);
    check("pin_2x2",    fmul(32'h40000000, 32'h40000000), 32'h40800000);

    step(); step();
    check("reset_m_prod", m_prod, 32'h0);
    resetn = 1'b1;
    step();

    // Single op: latency and value.
    s_valid = 1'b1; s_facA = 32'h40000000; s_facB = 32'h40400000;
    t = edge_n + 1;
    step();
    s_valid = 1'b0;
    k = 0;
    while (!m_valid && k < 20) begin
      step();
      k++;
    end
    check("single_m_valid", 32'(m_valid), 32'd1);
    check("single_latency", 32'(edge_n), 32'(t + L));
    check("single_prod", m_prod, 32'h40C00000);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("single_level0", 32'(level), 32'd0);
    check("single_busy0",  32'(busy),  32'd0);

    // Sign and ordering, back-to-back.
    popped.delete();
    m_ready = 1'b1;
    s_valid = 1'b1; s_facA = 32'h3FC00000; s_facB = 32'hC0000000;
    step();
    s_facA = 32'h40000000; s_facB = 32'h40000000;
    step();
    drain();
    check("order_count", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      check("order_first",  popped[0], 32'hC0400000);
      check("order_second", popped[1], 32'h40800000);
    end

    // Streaming at full rate.
    acc = 0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_facA = rand_float(); s_facB = rand_float();
      if (s_ready) acc++;
      step();
    end
    check("stream_accepts", 32'(acc), 32'd16);
    drain();

    // Back-pressure: credits stop admission at exactly D.
    acc = 0;
    popped.delete();
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_facA = rand_float(); s_facB = rand_float();
      if (s_ready) acc++;
      step();
    end
    s_valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'(D));
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    for (int i = 0; i < L + 1; i++) step();
    check("bp_level_full", 32'(level), 32'(D));
    m_ready = 1'b1;
    step();
    check("bp_s_ready_back", 32'(s_ready), 32'd1);
    drain();
    check("bp_drained", 32'(popped.size()), 32'(D));

    // Simultaneous push and pop at level 3.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_facA = rand_float(); s_facB = rand_float();
      step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < L; i++) step();
    check("pp_level3_pre", 32'(level), 32'd3);
    s_valid = 1'b1; s_facA = rand_float(); s_facB = rand_float();
    step();
    s_valid = 1'b0;
    for (int i = 0; i < L - 1; i++) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("pp_level3_post", 32'(level), 32'd3);
    drain();

    // Reset with 3 in flight and 2 buffered.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_facA = rand_float(); s_facB = rand_float();
      step();
    end
    s_valid = 1'b0;
    step();
    check("prerst_level", 32'(level), 32'd2);
    check("prerst_busy",  32'(busy),  32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_level",   32'(level),   32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_busy",    32'(busy),    32'd0);
    step();
    resetn  = 1'b1;
    m_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_valid) stale++;
    end
    check("no_stale", 32'(stale), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
